// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch sequencer that owns the architectural PC.
//
// Fetches the word at pc from instruction memory over a req/ack handshake,
// latches it in instr and presents it to the decoder. When the decoder
// consumes it, the block commits pcNext and starts the next fetch.
//
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   pcNext        next PC from the PC ALU, sampled only on a committed advance
//   pcAdvance     decoder has consumed instr; commit pcNext
//   stall         blocks an advance while high
//   memReq        instruction memory read request
//   memAddr       read address (always equal to pc)
//   memRdata      instruction word, valid with memAck
//   memAck        memory read complete
//   instr         latched instruction word (qualify with instrValid)
//   instrValid    instr holds the instruction at pc
//   pc            current program counter
//   retireCount   number of committed advances, wraps
//   dbgState      current FSM state (RST=0, FETCH=1, HOLD=2)
//
// Handshakes:
//   Memory side: memReq is held high with a stable memAddr until a rising edge
//   on which memAck is 1; memRdata is captured on that edge and memReq drops
//   the next cycle. An ack seen when no request is outstanding is ignored.
//   Decode side: instrValid acts as valid and (pcAdvance & ~stall) as ready;
//   the instruction is consumed on an edge where both are high.
module pc_fetch #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcNext,
  input  logic             pcAdvance,
  input  logic             stall,
  output logic             memReq,
  output logic [WIDTH-1:0] memAddr,
  input  logic [WIDTH-1:0] memRdata,
  input  logic             memAck,
  output logic [WIDTH-1:0] instr,
  output logic             instrValid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] retireCount,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] retire_count_q, retire_count_d;

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    instr_valid_d  = instr_valid_q;
    instr_d        = instr_q;
    pc_d           = pc_q;
    retire_count_d = retire_count_q;

    case (state_q)
      ST_RST: begin
        // A late ack from a fetch abandoned by reset lands here and is dropped.
        state_d   = ST_FETCH;
        mem_req_d = 1'b1;
      end
      ST_FETCH: begin
        if (memAck) begin
          instr_d       = memRdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // memAck is not looked at here so a stray ack cannot clobber instr.
        if (pcAdvance && !stall) begin
          pc_d           = pcNext;
          instr_valid_d  = 1'b0;
          retire_count_d = retire_count_q + WIDTH'(1);
          mem_req_d      = 1'b1;
          state_d        = ST_FETCH;
        end
      end
      default: begin
        state_d   = ST_RST;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RST;
      mem_req_q      <= 1'b0;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      pc_q           <= RESET_PC;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      instr_valid_q  <= instr_valid_d;
      instr_q        <= instr_d;
      pc_q           <= pc_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign memReq      = mem_req_q;
  assign memAddr     = pc_q;
  assign instr       = instr_q;
  assign instrValid  = instr_valid_q;
  assign pc          = pc_q;
  assign retireCount = retire_count_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: vector table, directed multi-cycle sequences,
// randomized run against a transaction-level model, and a narrow instance
// used to exercise retireCount wrap.
module tb_pc_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [15:0] pc_next_drv = '0;
  logic        pc_advance = 1'b0;
  logic        stall = 1'b0;
  logic        mem_ack_drv = 1'b0;
  logic [15:0] mem_rdata_drv = '0;
  logic        tie_ack = 1'b0;

  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr, pc, retire_count;
  logic [1:0]  dbg_state;
  logic        mem_ack;
  logic [15:0] mem_rdata, pc_next;

  // Zero-wait memory mode: ack follows request, data = addr + 0x100, next PC = pc + 1.
  assign mem_ack   = tie_ack ? mem_req : mem_ack_drv;
  assign mem_rdata = tie_ack ? (mem_addr + 16'h0100) : mem_rdata_drv;
  assign pc_next   = tie_ack ? (pc + 16'h0001) : pc_next_drv;

  pc_fetch #(.WIDTH(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .pcNext(pc_next), .pcAdvance(pc_advance),
    .stall(stall), .memReq(mem_req), .memAddr(mem_addr), .memRdata(mem_rdata),
    .memAck(mem_ack), .instr(instr), .instrValid(instr_valid), .pc(pc),
    .retireCount(retire_count), .dbgState(dbg_state)
  );

  // Narrow instance: zero-wait memory, always advancing when w4_run is high.
  logic       w4_run = 1'b0;
  logic       w4_req, w4_valid;
  logic [3:0] w4_addr, w4_instr, w4_pc, w4_rc;
  logic [1:0] w4_state;

  pc_fetch #(.WIDTH(4), .RESET_PC(4'h0)) u_dut_w4 (
    .clk(clk), .reset(reset), .pcNext(w4_pc + 4'h1), .pcAdvance(w4_run),
    .stall(1'b0), .memReq(w4_req), .memAddr(w4_addr), .memRdata(w4_addr),
    .memAck(w4_req), .instr(w4_instr), .instrValid(w4_valid), .pc(w4_pc),
    .retireCount(w4_rc), .dbgState(w4_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rst, input logic [15:0] nxt, input logic adv,
                       input logic stl, input logic ack, input logic [15:0] rdata);
    reset         = rst;
    pc_next_drv   = nxt;
    pc_advance    = adv;
    stall         = stl;
    mem_ack_drv   = ack;
    mem_rdata_drv = rdata;
  endtask

  task automatic do_reset(input int n);
    drive(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < n; i++) tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [15:0] e_addr,
                           input logic [15:0] e_instr, input logic e_valid,
                           input logic [15:0] e_pc, input logic [15:0] e_rc);
    check({tag, ".memReq"},      {31'b0, mem_req},     {31'b0, e_req});
    check({tag, ".memAddr"},     {16'b0, mem_addr},    {16'b0, e_addr});
    check({tag, ".instr"},       {16'b0, instr},       {16'b0, e_instr});
    check({tag, ".instrValid"},  {31'b0, instr_valid}, {31'b0, e_valid});
    check({tag, ".pc"},          {16'b0, pc},          {16'b0, e_pc});
    check({tag, ".retireCount"}, {16'b0, retire_count}, {16'b0, e_rc});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [15:0] nxt;
    logic        adv;
    logic        stl;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_rc;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  task automatic fill_vecs();
    //                rst   nxt    adv   stl   ack   rdata     req   addr     instr    valid pc       rc
    vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0100, 1'b1, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0100, 1'b0, 16'h0001, 16'h0001};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0001, 16'h0101, 1'b1, 16'h0001, 16'h0001};
    vecs[7]  = '{1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0101, 1'b0, 16'h0005, 16'h0002};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0105, 1'b0, 16'h0005, 16'h0105, 1'b1, 16'h0005, 16'h0002};
    vecs[9]  = '{1'b0, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h0105, 1'b1, 16'h0005, 16'h0002};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0005, 16'h0105, 1'b1, 16'h0005, 16'h0002};
    vecs[11] = '{1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0105, 1'b0, 16'h0040, 16'h0003};
    vecs[12] = '{1'b0, 16'h0099, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0105, 1'b0, 16'h0040, 16'h0003};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0140, 1'b0, 16'h0040, 16'h0140, 1'b1, 16'h0040, 16'h0003};
    vecs[14] = '{1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[16] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0BAD, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
  endtask

  // ---------------- test sequences ----------------
  task automatic run_table();
    fill_vecs();
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].nxt, vecs[i].adv, vecs[i].stl, vecs[i].ack, vecs[i].rdata);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
                vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_rc);
    end
  endtask

  task automatic run_zero_wait();
    logic [15:0] e;
    do_reset(2);
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(16'h0100 + 16'(k));
    tie_ack    = 1'b1;
    pc_advance = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      // Edge 0 leaves reset; an instruction becomes valid on every odd edge.
      check($sformatf("zw.valid%0d", j), {31'b0, instr_valid}, {31'b0, (j % 2) == 1});
      if (instr_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check($sformatf("zw.instr%0d", j), {16'b0, instr}, {16'b0, e});
      end
    end
    check("zw.retire", {16'b0, retire_count}, 32'd3);
    check("zw.sb_empty", exp_q.size(), 32'd0);
    tie_ack    = 1'b0;
    pc_advance = 1'b0;
  endtask

  task automatic run_stall_slow();
    do_reset(2);
    tick();                                            // now fetching pc 0
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);
    tick();                                            // holding 0x1234
    drive(1'b0, 16'h0022, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_all($sformatf("stall%0d", j), 1'b0, 16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000);
    end
    stall = 1'b0;
    tick();
    check_all("stall_rel", 1'b1, 16'h0022, 16'h1234, 1'b0, 16'h0022, 16'h0001);
    // Slow memory: five cycles without ack, request and address must hold.
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int j = 0; j < 5; j++) begin
      tick();
      check_all($sformatf("slow%0d", j), 1'b1, 16'h0022, 16'h1234, 1'b0, 16'h0022, 16'h0001);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5555);
    tick();
    check_all("slow_ack", 1'b0, 16'h0022, 16'h5555, 1'b1, 16'h0022, 16'h0001);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    for (int j = 0; j < 2; j++) begin
      tick();
      check_all($sformatf("spurious%0d", j), 1'b0, 16'h0022, 16'h5555, 1'b1, 16'h0022, 16'h0001);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Randomized run: the model only tracks "instruction waiting for the decoder",
  // the committed PC and the number of retirements.
  task automatic run_random(input int ncyc);
    logic [15:0] pc_m, cnt_m, nxt, rdata;
    logic        have_m, ack, adv, stl;
    int          lat;
    do_reset(2);
    tick();
    exp_q.delete();
    pc_m = 16'h0000; cnt_m = 16'h0000; have_m = 1'b0;
    lat = $urandom_range(0, 4);
    for (int c = 0; c < ncyc; c++) begin
      check("rnd.pc",      {16'b0, pc},           {16'b0, pc_m});
      check("rnd.memAddr", {16'b0, mem_addr},     {16'b0, pc_m});
      check("rnd.valid",   {31'b0, instr_valid},  {31'b0, have_m});
      check("rnd.memReq",  {31'b0, mem_req},      {31'b0, !have_m});
      check("rnd.retire",  {16'b0, retire_count}, {16'b0, cnt_m});
      if (have_m && exp_q.size() > 0)
        check("rnd.instr", {16'b0, instr}, {16'b0, exp_q[0]});
      nxt = 16'($urandom);
      adv = 1'($urandom_range(0, 1));
      if (have_m) begin
        ack   = ($urandom_range(0, 7) == 0);
        rdata = 16'hDEAD;
        stl   = ($urandom_range(0, 3) == 0);
      end else begin
        stl   = 1'b0;
        ack   = (lat == 0);
        rdata = mem_word(mem_addr);
        if (lat > 0) lat--;
      end
      drive(1'b0, nxt, adv, stl, ack, rdata);
      if (!have_m && ack) begin
        have_m = 1'b1;
        exp_q.push_back(mem_word(pc_m));
        lat = $urandom_range(0, 4);
      end else if (have_m && adv && !stl) begin
        have_m = 1'b0;
        pc_m   = nxt;
        cnt_m  = cnt_m + 16'h1;
        void'(exp_q.pop_front());
      end
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic run_wrap();
    logic [3:0] e;
    w4_run = 1'b0;
    do_reset(2);
    w4_run = 1'b1;
    for (int j = 1; j <= 35; j++) begin
      tick();
      // One retirement per two cycles, first one on the third edge after reset.
      e = 4'(((j - 1) / 2) % 16);
      check($sformatf("wrap%0d", j), {28'b0, w4_rc}, {28'b0, e});
    end
    w4_run = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    @(negedge clk);
    run_table();
    run_zero_wait();
    run_stall_slow();
    run_random(600);
    run_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction fetch sequencer that owns the architectural program counter. It consumes the next-PC value produced by the PC ALU, fetches from instruction memory over a req/ack handshake, and presents each instruction to the decoder with a valid/advance handshake. It sits between the instruction memory port and the decode/PC-ALU stage. The current `pc` output feeds back into the PC ALU.

## Interface
- `WIDTH`, 16, data, address and PC width.
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcNext`  in  WIDTH  next-PC value from the PC ALU; sampled only on an advance.
- `pcAdvance`  in  1  decoder has consumed the current instruction; commit `pcNext`.
- `stall`  in  1  hold request; blocks an advance.
- `memReq`  out  1  instruction memory read request.
- `memAddr`  out  WIDTH  read address; always equals `pc`.
- `memRdata`  in  WIDTH  instruction word from memory; valid when `memAck` = 1.
- `memAck`  in  1  memory read complete.
- `instr`  out  WIDTH  latched instruction word.
- `instrValid`  out  1  `instr` holds the instruction at `pc`.
- `pc`  out  WIDTH  current program counter.
- `retireCount`  out  WIDTH  count of committed advances; wraps.

## Operation
- The FSM has three states: RST, FETCH and HOLD.
- **RST:** entered on any cycle with `reset` = 1. The next cycle with `reset` = 0 moves to FETCH.
- **FETCH:**
  - Drives `memReq` = 1, with `memAddr` = `pc`.
  - On an edge with `memAck` = 1: `instr` <= `memRdata`, `instrValid` <= 1, `memReq` <= 0, go to HOLD.
  - `pcAdvance` is ignored in FETCH.
- **HOLD:**
  - `instrValid` = 1 and `memReq` = 0.
  - On an edge with `pcAdvance` = 1 and `stall` = 0: `pc` <= `pcNext`, `instrValid` <= 0, `retireCount` <= `retireCount` + 1, go to FETCH.
  - If `stall` = 1, the state, `pc` and `instr` hold, regardless of `pcAdvance`.
  - `memAck` is ignored in HOLD; a spurious ack does not overwrite `instr`.
- `pc` changes only on reset or on a committed advance. `pcNext` is taken verbatim, with no arithmetic in this block.
- `retireCount` wraps from 2^WIDTH-1 to 0.
- `instr` keeps its last value after `instrValid` falls; consumers must qualify it with `instrValid`.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`, `memReq` = 0, `instrValid` = 0, `instr` = 0, `retireCount` = 0, and the state is RST.
  - `memAddr` = `RESET_PC`.
- **Outputs:** all outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- **First request:** `memReq` rises on the first edge after `reset` falls.
- **Zero-wait memory:** `memAck` may be high in the same cycle `memReq` first rises. It is sampled at that cycle's edge, so `instrValid` is high the next cycle.
- **Throughput:** minimum 2 cycles per instruction, one in FETCH and one in HOLD with an immediate advance.
- **Request hold:** `memReq` stays high and `memAddr` stays stable until `memAck` is sampled. There is no timeout.
- **Reset mid-fetch:** the outstanding request is abandoned. `memReq` is 0 on the cycle after the reset edge. A late `memAck` arriving in RST is ignored.
- **Reset during HOLD:** `instrValid` drops on the reset edge and the advance is not committed, even if `pcAdvance` was high.

## Test plan
- **Reset:** hold `reset` 3 cycles, then release -> all outputs at reset values during reset; `memReq` = 1 and `memAddr` = 0x0000 on the first cycle after release.
- **Zero-wait sequence:** `memAck` tied to `memReq`, memory returns `addr`+0x100; advance every HOLD with `pcNext` = `pc`+1 -> `instr` = 0x0100, 0x0101, 0x0102 at 2-cycle spacing; `retireCount` = 3 after three advances.
- **Branch target:** in HOLD at `pc` = 0x0005, apply `pcNext` = 0x0040 with `pcAdvance` -> next `memAddr` = 0x0040; `pc` never passes through 0x0006.
- **Stall:** assert `stall` and `pcAdvance` together in HOLD for 4 cycles, then drop `stall` -> `pc`, `instr` and `instrValid` are unchanged for 4 cycles; the advance commits on the cycle `stall` drops.
- **Slow memory with spurious ack:** 5-cycle ack latency, plus a stray `memAck` with `memRdata` = 0xDEAD in HOLD -> `memReq` is held high 5 cycles with a stable address; `instr` is not overwritten by 0xDEAD.
- **Reset mid-fetch and counter wrap:**
  - Assert `reset` in FETCH with `memAck` arriving in the next cycle -> `memReq` = 0 and `instrValid` stays 0.
  - Preload `retireCount` to 0xFFFF via repeated advances, then advance once more -> 0x0000.
